// File: rtl/gemini_pkg.sv
// gemini_pkg: shared memory-op codes, access sizes and mem-stage FSM encoding
package gemini_pkg;
  typedef enum logic [3:0] {
    MEM_NONE = 4'd0, LB, LBU, LH, LHU, LW, SB, SH, SW
  } mem_op_t;
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  function automatic logic is_load(input logic [3:0] op);
    return op inside {LB, LBU, LH, LHU, LW};
  endfunction
  function automatic logic is_store(input logic [3:0] op);
    return op inside {SB, SH, SW};
  endfunction
  function automatic logic [1:0] op_size(input logic [3:0] op);
    return op inside {LH, LHU, SH} ? SIZE_H : op inside {LW, SW} ? SIZE_W : SIZE_B;
  endfunction
  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
    return (op_size(op) == SIZE_H && a[0]) || (op_size(op) == SIZE_W && a != 2'd0);
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/half lane of a load word and extends it
module load_align
  import gemini_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [3:0]  op,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{addr, 3'b000} +: 8];
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    data = op == LB  ? {{24{b[7]}}, b} :
           op == LBU ? {24'b0, b} :
           op == LH  ? {{16{h[15]}}, h} :
           op == LHU ? {16'b0, h} :
           op == LW  ? rdata : 32'b0;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage, one instruction in flight over a req/resp data bus
module mem_stage
  import gemini_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_mem_op,
  input  logic [31:0] in_alu_res,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_w_reg_dst,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        wb_valid,
  output logic        wb_sel,
  output logic [31:0] alu_res,
  output logic [31:0] mem_data,
  output logic [4:0]  w_reg_dst,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic [31:0] exc_badvaddr,
  output logic        stall
);
  state_t      state, next;
  logic [3:0]  op_q;
  logic [31:0] sdata_q, aligned;
  logic [4:0]  dst_q;
  logic        is_mem, bad, accept;
  assign is_mem = is_load(in_mem_op) || is_store(in_mem_op);
  assign bad    = is_mem && misaligned(in_mem_op, in_alu_res[1:0]);
  assign accept = state == IDLE && in_valid;
  always_ff @(posedge clk) state <= rst ? IDLE : next;
  always_comb begin
    next = state == IDLE ? (accept && is_mem && !bad ? REQ : IDLE) :
           state == REQ  ? (data_addr_ok ? WAIT : REQ) :
           state == WAIT ? (data_data_ok ? IDLE : WAIT) : IDLE;
  end
  // alu_res doubles as the latched bus address
  always_comb begin
    in_ready   = state == IDLE;
    stall      = !in_ready;
    data_req   = state == REQ;
    data_wr    = is_store(op_q);
    data_size  = op_size(op_q);
    data_addr  = alu_res;
    data_wdata = op_q == SB ? {4{sdata_q[7:0]}} : op_q == SH ? {2{sdata_q[15:0]}} : sdata_q;
    data_wstrb = op_q == SB ? 4'b0001 << alu_res[1:0] :
                 op_q == SH ? 4'b0011 << alu_res[1:0] :
                 op_q == SW ? 4'b1111 : 4'b0000;
  end
  load_align u_align (.rdata(data_rdata), .addr(alu_res[1:0]), .op(op_q), .data(aligned));
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= 4'd0;
      sdata_q      <= '0;
      dst_q        <= '0;
      wb_valid     <= 1'b0;
      wb_sel       <= 1'b0;
      alu_res      <= '0;
      mem_data     <= '0;
      w_reg_dst    <= '0;
      exc_adel     <= 1'b0;
      exc_ades     <= 1'b0;
      exc_badvaddr <= '0;
    end else begin
      wb_valid <= 1'b0;
      exc_adel <= 1'b0;
      exc_ades <= 1'b0;
      if (accept) begin
        op_q    <= in_mem_op;
        alu_res <= in_alu_res;
        sdata_q <= in_store_data;
        dst_q   <= in_w_reg_dst;
        if (!is_mem || bad) begin
          wb_valid     <= 1'b1;
          wb_sel       <= 1'b0;
          mem_data     <= '0;
          w_reg_dst    <= bad ? 5'd0 : in_w_reg_dst;
          exc_adel     <= bad && is_load(in_mem_op);
          exc_ades     <= bad && is_store(in_mem_op);
          exc_badvaddr <= bad ? in_alu_res : 32'd0;
        end
      end else if (state == WAIT && data_data_ok) begin
        wb_valid     <= 1'b1;
        wb_sel       <= is_load(op_q);
        mem_data     <= is_load(op_q) ? aligned : 32'd0;
        w_reg_dst    <= is_load(op_q) ? dst_q : 5'd0;
        exc_badvaddr <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table vectors, hand sequences and random ops against a lane-arithmetic model
module tb_mem_stage;
  import gemini_pkg::*;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, data_addr_ok = 0, data_data_ok = 0;
  logic [3:0]  in_mem_op = 0;
  logic [31:0] in_alu_res = 0, in_store_data = 0, data_rdata = 0;
  logic [4:0]  in_w_reg_dst = 0;
  logic        in_ready, data_req, data_wr, wb_valid, wb_sel, exc_adel, exc_ades, stall;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, alu_res, mem_data, exc_badvaddr;
  logic [3:0]  data_wstrb;
  logic [4:0]  w_reg_dst;
  int checks = 0, errors = 0;

  mem_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mem_op(in_mem_op),
    .in_alu_res(in_alu_res), .in_store_data(in_store_data), .in_w_reg_dst(in_w_reg_dst),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .wb_valid(wb_valid), .wb_sel(wb_sel),
    .alu_res(alu_res), .mem_data(mem_data), .w_reg_dst(w_reg_dst), .exc_adel(exc_adel),
    .exc_ades(exc_ades), .exc_badvaddr(exc_badvaddr), .stall(stall)
  );

  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr, sdata, rdata;
    logic [4:0]  dst;
    int          ad, dd;
    logic        req;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        sel;
    logic [31:0] mem;
    logic [4:0]  wdst;
    logic        adel, ades;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: derived from access width and byte offset, not from the RTL's lane muxes
  function automatic vec_t model(input logic [3:0] op, input logic [31:0] a, sd, rd,
                                 input logic [4:0] dst, input int ad, dd);
    vec_t v;
    int nb, off;
    bit ld, st, sgn, mis;
    bit [31:0] mask, val;
    ld  = op >= 4'd1 && op <= 4'd5;
    st  = op >= 4'd6 && op <= 4'd8;
    nb  = op inside {LB, LBU, SB} ? 1 : op inside {LH, LHU, SH} ? 2 : op inside {LW, SW} ? 4 : 0;
    sgn = op inside {LB, LH};
    off = int'(a % 4);
    mis = nb > 0 && (off % nb) != 0;
    mask = nb == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 1;
    val  = (rd >> (8 * off)) & mask;
    if (sgn && nb > 0 && val[8 * nb - 1]) val = val | ~mask;
    v.op = op; v.addr = a; v.sdata = sd; v.rdata = rd; v.dst = dst; v.ad = ad; v.dd = dd;
    v.req   = nb > 0 && !mis;
    v.size  = nb == 1 ? 2'd0 : nb == 2 ? 2'd1 : 2'd2;
    v.wdata = nb == 1 ? (sd & 32'hFF) * 32'h0101_0101 : nb == 2 ? (sd & 32'hFFFF) * 32'h0001_0001 : sd;
    v.wstrb = st ? 4'((32'd1 << nb) - 1) << off : 4'd0;
    v.sel   = ld && !mis;
    v.mem   = val;
    v.wdst  = (mis || st) ? 5'd0 : dst;
    v.adel  = mis && ld;
    v.ades  = mis && st;
    return v;
  endfunction

  // Accepts one op; returns in the cycle wb_valid is expected high
  task automatic run(input vec_t v, input bit noise);
    bit st;
    st = v.op inside {SB, SH, SW};
    chk("in_ready_before_accept", in_ready, 1);
    in_valid = 1; in_mem_op = v.op; in_alu_res = v.addr; in_store_data = v.sdata; in_w_reg_dst = v.dst;
    tick;
    in_valid = 0; in_mem_op = 4'($urandom_range(0, 8)); in_alu_res = $urandom; in_store_data = $urandom;
    if (v.req) begin
      for (int k = 0; k <= v.ad; k++) begin
        chk("req_high", data_req, 1);
        chk("req_in_ready", in_ready, 0);
        chk("req_stall", stall, 1);
        chk("req_wb_valid", wb_valid, 0);
        chk("req_addr", data_addr, v.addr);
        chk("req_size", data_size, v.size);
        chk("req_wr", data_wr, st);
        if (st) begin
          chk("req_wdata", data_wdata, v.wdata);
          chk("req_wstrb", data_wstrb, v.wstrb);
        end
        data_addr_ok = k == v.ad;
        data_data_ok = noise ? 1'($urandom) : 1'b0;
        data_rdata = $urandom;
        tick;
      end
      data_addr_ok = 0; data_data_ok = 0;
      for (int k = 0; k < v.dd; k++) begin
        chk("wait_req_low", data_req, 0);
        chk("wait_in_ready", in_ready, 0);
        chk("wait_wb_valid", wb_valid, 0);
        tick;
      end
      data_data_ok = 1; data_rdata = v.rdata;
      tick;
      data_data_ok = 0; data_rdata = $urandom;
    end else
      chk("no_req", data_req, 0);
    chk("wb_valid", wb_valid, 1);
    chk("wb_sel", wb_sel, v.sel);
    chk("alu_res", alu_res, v.addr);
    chk("w_reg_dst", w_reg_dst, v.dst === v.wdst ? v.dst : v.wdst);
    chk("exc_adel", exc_adel, v.adel);
    chk("exc_ades", exc_ades, v.ades);
    if (v.adel || v.ades) chk("exc_badvaddr", exc_badvaddr, v.addr);
    if (v.sel) chk("mem_data", mem_data, v.mem);
    chk("wb_in_ready", in_ready, 1);
  endtask

  vec_t tbl[11];
  initial begin
    //         op        addr          sdata         rdata         dst ad dd req sz wdata         wstrb sel mem           wdst adel ades
    tbl[0]  = '{MEM_NONE, 32'h0000_1234, 32'h0,        32'h0,        5, 0, 0, 0, 0, 32'h0,        4'h0, 0, 32'h0,        5, 0, 0};
    tbl[1]  = '{LB,       32'h0000_1003, 32'h0,        32'h80FF_FFFF, 7, 2, 0, 1, 0, 32'h0,        4'h0, 1, 32'hFFFF_FF80, 7, 0, 0};
    tbl[2]  = '{LHU,      32'h0000_2002, 32'h0,        32'h8001_0000, 8, 0, 0, 1, 1, 32'h0,        4'h0, 1, 32'h0000_8001, 8, 0, 0};
    tbl[3]  = '{LH,       32'h0000_2002, 32'h0,        32'h8001_0000, 8, 1, 2, 1, 1, 32'h0,        4'h0, 1, 32'hFFFF_8001, 8, 0, 0};
    tbl[4]  = '{SB,       32'h0000_3001, 32'h0000_00AB, 32'h0,        9, 0, 1, 1, 0, 32'hABAB_ABAB, 4'h2, 0, 32'h0,        0, 0, 0};
    tbl[5]  = '{LW,       32'h0000_4002, 32'h0,        32'h0,        3, 0, 0, 0, 2, 32'h0,        4'h0, 0, 32'h0,        0, 1, 0};
    tbl[6]  = '{SH,       32'h0000_4001, 32'h0000_5555, 32'h0,        3, 0, 0, 0, 1, 32'h0,        4'h0, 0, 32'h0,        0, 0, 1};
    tbl[7]  = '{SW,       32'h0000_5000, 32'hDEAD_BEEF, 32'h0,        4, 1, 1, 1, 2, 32'hDEAD_BEEF, 4'hF, 0, 32'h0,        0, 0, 0};
    tbl[8]  = '{SH,       32'h0000_5002, 32'hFFFF_1234, 32'h0,        4, 0, 0, 1, 1, 32'h1234_1234, 4'hC, 0, 32'h0,        0, 0, 0};
    tbl[9]  = '{LBU,      32'h0000_6001, 32'h0,        32'h1234_80CD, 6, 0, 3, 1, 0, 32'h0,        4'h0, 1, 32'h0000_0080, 6, 0, 0};
    tbl[10] = '{LW,       32'h0000_7000, 32'h0,        32'hCAFE_F00D, 31, 3, 0, 1, 2, 32'h0,       4'h0, 1, 32'hCAFE_F00D, 31, 0, 0};

    tick; tick;
    rst = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_data_req", data_req, 0);
    chk("rst_data_wr", data_wr, 0);
    chk("rst_data_size", data_size, 0);
    chk("rst_data_addr", data_addr, 0);
    chk("rst_data_wdata", data_wdata, 0);
    chk("rst_data_wstrb", data_wstrb, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_sel", wb_sel, 0);
    chk("rst_alu_res", alu_res, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_w_reg_dst", w_reg_dst, 0);
    chk("rst_exc", {exc_adel, exc_ades}, 0);
    chk("rst_badvaddr", exc_badvaddr, 0);

    foreach (tbl[i]) run(tbl[i], 0);
    run(tbl[0], 0);
    tick;
    chk("wb_pulse_ends", wb_valid, 0);

    // Reset while waiting for the response; the late response must be dropped
    in_valid = 1; in_mem_op = LW; in_alu_res = 32'h8000; in_w_reg_dst = 2;
    tick;
    in_valid = 0; data_addr_ok = 1;
    tick;
    data_addr_ok = 0; rst = 1;
    tick;
    rst = 0;
    chk("rstmid_req", data_req, 0);
    chk("rstmid_in_ready", in_ready, 1);
    chk("rstmid_wb_valid", wb_valid, 0);
    data_data_ok = 1; data_rdata = 32'h1111_1111;
    tick;
    data_data_ok = 0;
    chk("late_ok_wb_valid", wb_valid, 0);
    chk("late_ok_in_ready", in_ready, 1);
    chk("late_ok_req", data_req, 0);
    run(tbl[0], 0);
    tick;

    for (int n = 0; n < 80; n++) begin
      logic [3:0] op;
      logic [31:0] a;
      op = 4'($urandom_range(0, 8));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'($urandom_range(0, 1) * 2 * (op inside {LW, SW} ? 0 : 1));
      run(model(op, a, $urandom, $urandom, 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3)), 1);
      if ($urandom_range(0, 1) == 1) begin
        tick;
        chk("rand_wb_pulse_ends", wb_valid, 0);
      end
    end
    tick;
    chk("final_wb_idle", wb_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
